// File: rtl/clap_pkg.sv
// Shared types and constants for the clap command decoder.
// Default timing assumes a 50 MHz core clock.
package clap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    QUALIFY,
    RELEASE,
    WINDOW,
    EMIT,
    LOCKOUT
  } state_t;

  localparam logic [1:0] CMD_NONE   = 2'd0;
  localparam logic [1:0] CMD_SINGLE = 2'd1;
  localparam logic [1:0] CMD_DOUBLE = 2'd2;
  localparam logic [1:0] CMD_TRIPLE = 2'd3;

  localparam int DEF_HOLD_CYCLES   = 4;
  localparam int DEF_GAP_CYCLES    = 2_500_000;
  localparam int DEF_WINDOW_CYCLES = 25_000_000;

  function automatic int timer_width(input int gap, input int win);
    return $clog2(((gap > win) ? gap : win) + 1);
  endfunction

endpackage

// File: rtl/clap_command_decoder_cycle_timer.sv
// Saturating up-counter with synchronous clear and a "reached terminal" flag.
// done is combinational on the current count so the FSM can act in the same cycle.
module cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] terminal,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

  // >= rather than == so a count that ran past terminal still reads as expired
  assign done = (count >= terminal);

endmodule

// File: rtl/clap_command_decoder.sv
// Decodes single/double/triple clap sequences into commands that toggle a light and fan.
// Clap input is registered once, so every transition lags the raw input by one cycle.
import clap_pkg::*;

module clap_command_decoder #(
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       clap,
  output logic       cmd_valid,
  output logic [1:0] cmd_code,
  output logic       light_on,
  output logic       fan_on,
  output logic [1:0] clap_count
);

  localparam int TW = timer_width(GAP_CYCLES, WINDOW_CYCLES);
  localparam logic [TW-1:0] HOLD_TERM   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_TERM    = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] WINDOW_TERM = TW'(WINDOW_CYCLES - 1);

  state_t     state;
  logic       clap_q;
  logic       hold_clr, gap_clr, win_clr, win_en;
  logic       hold_done, gap_done, win_done;
  logic [1:0] count_inc;

  always_ff @(posedge clk) begin
    if (reset) clap_q <= 1'b0;
    else       clap_q <= clap;
  end

  // The cycle that moves IDLE/WINDOW into QUALIFY already counts as the first high cycle.
  assign hold_clr = !enable || !clap_q || !(state inside {IDLE, QUALIFY, WINDOW});
  assign gap_clr  = !enable || clap_q || !(state inside {RELEASE, LOCKOUT});
  // Window keeps its value across QUALIFY so a rejected glitch resumes the wait.
  assign win_clr  = !enable || !(state inside {WINDOW, QUALIFY});
  assign win_en   = (state == WINDOW);

  cycle_timer #(.W(TW)) u_hold (
    .clk(clk), .reset(reset), .clear(hold_clr), .en(1'b1),
    .terminal(HOLD_TERM), .done(hold_done)
  );

  cycle_timer #(.W(TW)) u_gap (
    .clk(clk), .reset(reset), .clear(gap_clr), .en(1'b1),
    .terminal(GAP_TERM), .done(gap_done)
  );

  cycle_timer #(.W(TW)) u_window (
    .clk(clk), .reset(reset), .clear(win_clr), .en(win_en),
    .terminal(WINDOW_TERM), .done(win_done)
  );

  assign count_inc = (clap_count == 2'd3) ? 2'd3 : clap_count + 2'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      clap_count <= 2'd0;
      cmd_valid  <= 1'b0;
      cmd_code   <= CMD_NONE;
      light_on   <= 1'b0;
      fan_on     <= 1'b0;
    end else if (!enable) begin
      state      <= IDLE;
      clap_count <= 2'd0;
      cmd_valid  <= 1'b0;
      cmd_code   <= CMD_NONE;
    end else begin
      cmd_valid <= 1'b0;
      cmd_code  <= CMD_NONE;
      case (state)
        IDLE: begin
          if (clap_q) state <= QUALIFY;
        end
        QUALIFY: begin
          if (clap_q) begin
            if (hold_done) begin
              clap_count <= count_inc;
              if (count_inc == 2'd3) begin
                state     <= EMIT;
                cmd_valid <= 1'b1;
                cmd_code  <= count_inc;
              end else begin
                state <= RELEASE;
              end
            end
          end else begin
            state <= (clap_count == 2'd0) ? IDLE : WINDOW;
          end
        end
        RELEASE: begin
          if (!clap_q && gap_done) state <= WINDOW;
        end
        WINDOW: begin
          if (clap_q) begin
            state <= QUALIFY;
          end else if (win_done) begin
            state     <= EMIT;
            cmd_valid <= 1'b1;
            cmd_code  <= clap_count;
          end
        end
        EMIT: begin
          state <= LOCKOUT;
          case (cmd_code)
            CMD_SINGLE: light_on <= ~light_on;
            CMD_DOUBLE: fan_on   <= ~fan_on;
            CMD_TRIPLE: begin
              light_on <= 1'b0;
              fan_on   <= 1'b0;
            end
            default: ;
          endcase
        end
        LOCKOUT: begin
          if (!clap_q && gap_done) begin
            state      <= IDLE;
            clap_count <= 2'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clap_command_decoder.sv
// Directed bench for clap_command_decoder with short timing parameters.
module tb_clap_command_decoder;

  logic       clk = 1'b0;
  logic       reset, enable, clap;
  logic       cmd_valid, light_on, fan_on;
  logic [1:0] cmd_code, clap_count;

  int         n_vec  = 0;
  int         n_miss = 0;
  int         n_cmd  = 0;
  logic [1:0] last_code = 2'd0;
  logic       code_leak = 1'b0;

  clap_command_decoder #(
    .HOLD_CYCLES(4), .GAP_CYCLES(8), .WINDOW_CYCLES(40)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clap(clap),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .light_on(light_on), .fan_on(fan_on), .clap_count(clap_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_valid) begin
      n_cmd     = n_cmd + 1;
      last_code = cmd_code;
    end else if (cmd_code != 2'd0) begin
      code_leak = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic v, input int n);
    repeat (n) begin
      @(negedge clk);
      clap = v;
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    clap   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst cmd_valid", 32'(cmd_valid), 0);
    chk("rst cmd_code", 32'(cmd_code), 0);
    chk("rst light", 32'(light_on), 0);
    chk("rst fan", 32'(fan_on), 0);
    chk("rst count", 32'(clap_count), 0);
    reset = 1'b0;
    cyc(1'b0, 4);

    // single clap
    n_cmd = 0;
    cyc(1'b1, 10);
    cyc(1'b0, 12);
    chk("single mid count", 32'(clap_count), 1);
    cyc(1'b0, 60);
    chk("single n_cmd", 32'(n_cmd), 1);
    chk("single code", 32'(last_code), 1);
    chk("single light", 32'(light_on), 1);
    chk("single fan", 32'(fan_on), 0);
    chk("single end count", 32'(clap_count), 0);

    // double clap
    n_cmd = 0;
    cyc(1'b1, 6);
    cyc(1'b0, 20);
    cyc(1'b1, 6);
    cyc(1'b0, 70);
    chk("double n_cmd", 32'(n_cmd), 1);
    chk("double code", 32'(last_code), 2);
    chk("double fan", 32'(fan_on), 1);
    chk("double light", 32'(light_on), 1);

    // triple clap, third one held; emitted well before a window could expire
    n_cmd = 0;
    cyc(1'b1, 6);
    cyc(1'b0, 12);
    cyc(1'b1, 6);
    cyc(1'b0, 12);
    cyc(1'b1, 10);
    chk("triple n_cmd early", 32'(n_cmd), 1);
    chk("triple code", 32'(last_code), 3);
    chk("triple light", 32'(light_on), 0);
    chk("triple fan", 32'(fan_on), 0);
    cyc(1'b1, 20);
    cyc(1'b0, 20);
    chk("triple held n_cmd", 32'(n_cmd), 1);
    chk("triple end count", 32'(clap_count), 0);

    // glitch rejection
    n_cmd = 0;
    cyc(1'b1, 3);
    cyc(1'b0, 100);
    chk("glitch n_cmd", 32'(n_cmd), 0);
    chk("glitch count", 32'(clap_count), 0);

    // set light_on so the aborts below have something to preserve or clear
    n_cmd = 0;
    cyc(1'b1, 6);
    cyc(1'b0, 70);
    chk("pre-abort light", 32'(light_on), 1);

    // enable-low abort during WINDOW
    n_cmd = 0;
    cyc(1'b1, 6);
    cyc(1'b0, 15);
    chk("en abort mid count", 32'(clap_count), 1);
    @(negedge clk) enable = 1'b0;
    @(negedge clk) enable = 1'b1;
    cyc(1'b0, 70);
    chk("en abort n_cmd", 32'(n_cmd), 0);
    chk("en abort count", 32'(clap_count), 0);
    chk("en abort light", 32'(light_on), 1);
    chk("en abort fan", 32'(fan_on), 0);

    // reset abort during WINDOW
    n_cmd = 0;
    cyc(1'b1, 6);
    cyc(1'b0, 15);
    chk("rst abort mid count", 32'(clap_count), 1);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    cyc(1'b0, 70);
    chk("rst abort n_cmd", 32'(n_cmd), 0);
    chk("rst abort count", 32'(clap_count), 0);
    chk("rst abort light", 32'(light_on), 0);
    chk("rst abort fan", 32'(fan_on), 0);

    // second clap seen by the FSM on the exact window-expiry cycle
    n_cmd = 0;
    cyc(1'b1, 6);
    cyc(1'b0, 47);
    cyc(1'b1, 6);
    cyc(1'b0, 70);
    chk("boundary n_cmd", 32'(n_cmd), 1);
    chk("boundary code", 32'(last_code), 2);
    chk("boundary fan", 32'(fan_on), 1);
    chk("boundary light", 32'(light_on), 0);

    chk("idle cmd_code zero", 32'(code_leak), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
